universal_shift_register_p: RTL

- Parametrised successor to the team's 4-bit universal shift register.
- Adds the following over that block:
  - WIDTH generalisation.
  - Rotate and arithmetic-shift modes.
  - Serial in/out on both ends.
  - A multi-cycle "shift-by-N" engine with a busy/done handshake.
- Sits as a datapath utility for serialisers, barrel-shift emulation and bit-stream test logic.

---
 rtl/usr_pkg.sv | 22 ++
 rtl/usr_step_fn.sv | 37 +++
 rtl/universal_shift_register_p.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register.
//   usr_mode_e  : 3-bit mode select encodings
//   usr_state_e : multi-step engine states
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SR   = 3'b001,
    MODE_SL   = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_RR   = 3'b100,
    MODE_RL   = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } usr_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } usr_state_e;

endpackage

// File: rtl/usr_step_fn.sv
// Combinational one-step next-value function of the shift register.
// Ports:
//   mode    : operation to apply (usr_mode_e)
//   cur     : current register value
//   sin_msb : serial bit entering the MSB on shift right
//   sin_lsb : serial bit entering the LSB on shift left
//   parin   : parallel load data
//   nxt     : value after one step
module usr_step_fn
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  usr_mode_e        mode,
  input  logic [WIDTH-1:0] cur,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  input  logic [WIDTH-1:0] parin,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    unique case (mode)
      MODE_SR:   nxt = {sin_msb, cur[WIDTH-1:1]};
      MODE_SL:   nxt = {cur[WIDTH-2:0], sin_lsb};
      MODE_LOAD: nxt = parin;
      MODE_RR:   nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_RL:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      MODE_HOLD,
      MODE_RSVD: nxt = cur;
      default:   nxt = cur;
    endcase
  end

endmodule

// File: rtl/universal_shift_register_p.sv
// Parametrised universal shift register with single-step and multi-step
// (shift-by-N) operation.
// Optional feature: define USR_ZERO_FLAG_EN to add the registered 'zero' flag.
// Ports:
//   clk      : rising-edge clock
//   clr      : asynchronous active-high reset
//   en       : single-step enable (IDLE only)
//   sel      : mode select (see usr_pkg::usr_mode_e)
//   parin    : parallel load data
//   sin_msb  : serial in at MSB (shift right)
//   sin_lsb  : serial in at LSB (shift left)
//   start    : launch a multi-step operation of amt steps
//   amt      : step count, clamped to WIDTH
//   out      : register contents
//   sout_lsb : out[0]
//   sout_msb : out[WIDTH-1]
//   busy     : multi-step operation in progress
//   done     : one-cycle completion pulse
//   zero     : (USR_ZERO_FLAG_EN) out is all zeros
module universal_shift_register_p
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] parin,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] out,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic             busy,
  output logic             done
`ifdef USR_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  usr_state_e       state_q, state_d;
  usr_mode_e        mode_q, mode_d;
  usr_mode_e        step_mode;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [AMT_W-1:0] amt_clamped;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] step_val;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One step-function instance serves both paths: the latched mode while
  // running, the live select while idle.
  assign step_mode = (state_q == RUN) ? mode_q : usr_mode_e'(sel);

  usr_step_fn #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode    (step_mode),
    .cur     (out_q),
    .sin_msb (sin_msb),
    .sin_lsb (sin_lsb),
    .parin   (parin),
    .nxt     (step_val)
  );

  assign amt_clamped = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = usr_mode_e'(sel);
          cnt_d  = amt_clamped;
          if (amt_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else if (en) begin
          out_d = step_val;
        end
      end
      RUN: begin
        out_d = step_val;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef USR_ZERO_FLAG_EN
  logic zero_q, zero_d;

  // Computed from the next value so the flag lands in the same cycle as out.
  assign zero_d = (out_d == '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

  assign out      = out_q;
  assign sout_lsb = out_q[0];
  assign sout_msb = out_q[WIDTH-1];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
